inst_fetch_unit: RTL and testbench

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

---
 rtl/inst_fetch_unit.sv | 91 +++++++++
 tb/tb_inst_fetch_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: one outstanding fetch at a time, REQ/WAIT/HOLD
// handshakes toward memory and decode, with branch redirect at retire.
`timescale 1ns/1ps
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        inst_req_valid,
  input  logic        inst_req_ready,
  output logic [31:0] inst_addr,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [31:0] inst_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_INIT,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] cnt_q, cnt_d;
  logic        unused_redirect_lsbs;

  // targets are word aligned; the low bits are dropped
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0;
      cnt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_INIT: state_d = S_REQ;
      S_REQ: begin
        if (inst_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (inst_valid) begin
          ir_d    = inst_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (id_ready) begin
          pc_d    = redirect_valid ?
                    {redirect_pc[31:2], 2'b00} :
                    pc_q + 32'd4;
          cnt_d   = cnt_q + 32'd1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  assign inst_req_valid = (state_q == S_REQ);
  assign inst_ready     = (state_q == S_WAIT);
  assign id_valid       = (state_q == S_HOLD);
  assign inst_addr      = pc_q;
  assign id_pc          = pc_q;
  assign id_inst        = ir_q;
  assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: two instances (reset PC 0 and 0xFFFF_FFFC)
// share stimulus; a transaction model is compared every cycle.
`timescale 1ns/1ps
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rq, iv, idr, rv;
  logic [31:0] rd, rpc;

  logic        a_req, a_rdy, a_idv;
  logic [31:0] a_addr, a_inst, a_pc, a_cnt;
  logic        w_req, w_rdy, w_idv;
  logic [31:0] w_addr, w_inst, w_pc, w_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .inst_req_valid(a_req), .inst_req_ready(rq),
    .inst_addr(a_addr), .inst_valid(iv),
    .inst_ready(a_rdy), .inst_rdata(rd),
    .id_valid(a_idv), .id_ready(idr),
    .id_inst(a_inst), .id_pc(a_pc),
    .redirect_valid(rv), .redirect_pc(rpc),
    .fetch_count(a_cnt)
  );

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .inst_req_valid(w_req), .inst_req_ready(rq),
    .inst_addr(w_addr), .inst_valid(iv),
    .inst_ready(w_rdy), .inst_rdata(rd),
    .id_valid(w_idv), .id_ready(idr),
    .id_inst(w_inst), .id_pc(w_pc),
    .redirect_valid(rv), .redirect_pc(rpc),
    .fetch_count(w_cnt)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Transaction model: where the one outstanding fetch currently is
  localparam int PH_IDLE = 0;
  localparam int PH_ASK  = 1;
  localparam int PH_MEM  = 2;
  localparam int PH_DEC  = 3;

  int          m_ph;
  logic [31:0] m_pc, m_pcw, m_ir, m_cnt;

  function automatic logic [31:0] nxt(input logic [31:0] pc);
    logic [32:0] s;
    if (rv) return rpc & 32'hFFFF_FFFC;
    s = {1'b0, pc} + 33'd4;
    return s[31:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph  <= PH_IDLE;
      m_pc  <= 32'h0000_0000;
      m_pcw <= 32'hFFFF_FFFC;
      m_ir  <= 32'h0;
      m_cnt <= 32'h0;
    end else if (m_ph == PH_IDLE) begin
      m_ph <= PH_ASK;
    end else if (m_ph == PH_ASK && rq) begin
      m_ph <= PH_MEM;
    end else if (m_ph == PH_MEM && iv) begin
      m_ir <= rd;
      m_ph <= PH_DEC;
    end else if (m_ph == PH_DEC && idr) begin
      m_pc  <= nxt(m_pc);
      m_pcw <= nxt(m_pcw);
      m_cnt <= m_cnt + 32'd1;
      m_ph  <= PH_ASK;
    end
  end

  always @(negedge clk) begin
    chk("req_valid", {31'b0, a_req}, {31'b0, m_ph == PH_ASK});
    chk("inst_ready", {31'b0, a_rdy}, {31'b0, m_ph == PH_MEM});
    chk("id_valid", {31'b0, a_idv}, {31'b0, m_ph == PH_DEC});
    chk("inst_addr", a_addr, m_pc);
    chk("id_pc", a_pc, m_pc);
    chk("id_inst", a_inst, m_ir);
    chk("fetch_count", a_cnt, m_cnt);
    chk("onehot", {31'b0, (a_req + a_rdy + a_idv) <= 2'd1}, 32'd1);
    chk("w_req_valid", {31'b0, w_req}, {31'b0, m_ph == PH_ASK});
    chk("w_inst_addr", w_addr, m_pcw);
    chk("w_id_pc", w_pc, m_pcw);
    chk("w_id_inst", w_inst, m_ir);
    chk("w_fetch_count", w_cnt, m_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    rq = 0; iv = 0; idr = 0; rv = 0;
    rd = 32'h0; rpc = 32'h0;
    repeat (3) tick();
    chk("rst_addr", a_addr, 32'h0);
    chk("rst_inst", a_inst, 32'h0);
    chk("rst_cnt", a_cnt, 32'h0);
    chk("rst_req", {31'b0, a_req}, 32'h0);
    chk("rst_waddr", w_addr, 32'hFFFF_FFFC);

    // sequential fetch, everything ready
    rq = 1; iv = 1; idr = 1; rd = 32'h0000_0013;
    rst_n = 1'b1;
    tick();
    chk("seq0_req", {31'b0, a_req}, 32'd1);
    chk("seq0_addr", a_addr, 32'h0);
    chk("wrap0_addr", w_addr, 32'hFFFF_FFFC);
    repeat (3) tick();
    chk("seq1_req", {31'b0, a_req}, 32'd1);
    chk("seq1_addr", a_addr, 32'h4);
    chk("wrap1_addr", w_addr, 32'h0);
    repeat (3) tick();
    chk("seq2_addr", a_addr, 32'h8);
    repeat (3) tick();
    chk("seq_cnt3", a_cnt, 32'd3);

    // spurious inputs in REQ then WAIT, redirect pulse in WAIT
    rq = 0; iv = 1; rd = 32'h5555_5555; idr = 1;
    repeat (2) tick();
    chk("spur_req", {31'b0, a_req}, 32'd1);
    chk("spur_ir", a_inst, 32'h0000_0013);
    rq = 1; iv = 0;
    tick();
    rv = 1; rpc = 32'h0000_2000;
    repeat (2) tick();
    chk("spur_wait", {31'b0, a_rdy}, 32'd1);
    chk("spur_cnt", a_cnt, 32'd3);
    rv = 0; idr = 0; iv = 1; rd = 32'h1234_5678;
    tick();
    chk("hold_inst", a_inst, 32'h1234_5678);
    chk("hold_pc", a_pc, 32'h0000_000C);
    idr = 1; iv = 0;
    tick();
    chk("noredir_addr", a_addr, 32'h0000_0010);
    chk("cnt4", a_cnt, 32'd4);

    // redirect taken at the HOLD handshake
    iv = 1; rd = 32'h0000_0093;
    rv = 1; rpc = 32'h0000_1003;
    repeat (3) tick();
    chk("redir_addr", a_addr, 32'h0000_1000);
    chk("redir_waddr", w_addr, 32'h0000_1000);
    rv = 0; rpc = 32'h0;

    // backpressure on every handshake
    rq = 0; iv = 0; idr = 0;
    repeat (5) begin
      tick();
      chk("bp_addr", a_addr, 32'h0000_1000);
    end
    rq = 1;
    tick();
    rq = 0;
    repeat (4) begin
      tick();
      chk("bp_wait", {31'b0, a_rdy}, 32'd1);
    end
    rd = 32'hCAFE_F00D; iv = 1;
    tick();
    iv = 0; rd = 32'h0;
    repeat (6) begin
      tick();
      chk("bp_inst", a_inst, 32'hCAFE_F00D);
      chk("bp_pc", a_pc, 32'h0000_1000);
      chk("bp_cnt", a_cnt, 32'd5);
    end
    idr = 1;
    tick();
    chk("bp_next", a_addr, 32'h0000_1004);
    chk("bp_cnt6", a_cnt, 32'd6);

    // reset asserted mid-WAIT between edges
    rq = 1;
    tick();
    chk("mr_wait", {31'b0, a_rdy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_drop", {31'b0, a_rdy}, 32'd0);
    chk("mr_inst", a_inst, 32'h0);
    chk("mr_cnt", a_cnt, 32'h0);
    iv = 1; rd = 32'hDEAD_BEEF;
    repeat (2) tick();
    chk("mr_late", a_inst, 32'h0);
    iv = 0;
    rst_n = 1'b1;
    tick();
    chk("mr_first", a_addr, 32'h0);
    chk("mr_req", {31'b0, a_req}, 32'd1);
    chk("mr_wfirst", w_addr, 32'hFFFF_FFFC);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
